// File: rtl/flash_pkg.sv
// Shared definitions for the flash slot loader: SPI opcode, loader states, CRC helper.
package flash_pkg;

  localparam logic [7:0]  SPI_READ = 8'h03;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {IDLE, CMD, STREAM, PAD, DONE} load_state_t;

  // CRC-16/CCITT, MSB first, one byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_flash_stream.sv
// SPI mode-0 read engine: sends READ + 24-bit address at clock/2, then streams
// bytes on one csn-low burst, parking sck low while a received byte is unaccepted.
module spi_flash_stream
  import flash_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_ack,
  input  logic [23:0] i_addr,
  input  logic        i_miso,
  output logic        o_csn,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_streaming,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte_data
);

  logic        r_active;
  logic        r_cmd;
  logic        r_csn;
  logic        r_sck;
  logic        r_mosi;
  logic [31:0] r_tx;
  logic [4:0]  r_bitcnt;
  logic [6:0]  r_rx;
  logic [2:0]  r_rxcnt;
  logic        r_valid;
  logic [7:0]  r_data;

  always_ff @(posedge clock) begin
    if (reset || i_stop) begin
      r_active <= 1'b0;
      r_cmd    <= 1'b0;
      r_csn    <= 1'b1;
      r_sck    <= 1'b0;
      r_mosi   <= 1'b0;
      r_bitcnt <= '0;
      r_rxcnt  <= '0;
      r_valid  <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cmd    <= 1'b1;
      r_csn    <= 1'b0;
      r_sck    <= 1'b0;
      r_mosi   <= SPI_READ[7];
      r_tx     <= {SPI_READ, i_addr};
      r_bitcnt <= '0;
      r_rxcnt  <= '0;
      r_valid  <= 1'b0;
    end else if (r_active) begin
      if (i_ack) r_valid <= 1'b0;
      if (r_cmd) begin
        r_sck <= ~r_sck;
        // mosi advances on the falling sck so it is stable for the next rise
        if (r_sck) begin
          r_tx     <= {r_tx[30:0], 1'b0};
          r_mosi   <= r_tx[30];
          r_bitcnt <= r_bitcnt + 5'd1;
          if (r_bitcnt == 5'd31) begin
            r_cmd  <= 1'b0;
            r_mosi <= 1'b0;
          end
        end
      end else if (r_sck) begin
        r_sck   <= 1'b0;
        r_rx    <= {r_rx[5:0], i_miso};
        r_rxcnt <= r_rxcnt + 3'd1;
        if (r_rxcnt == 3'd7) begin
          r_data  <= {r_rx, i_miso};
          r_valid <= 1'b1;
        end
      end else if (!r_valid || i_ack) begin
        r_sck <= 1'b1;
      end
    end
  end

  assign o_csn        = r_csn;
  assign o_sck        = r_sck;
  assign o_mosi       = r_mosi;
  assign o_streaming  = r_active && !r_cmd;
  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_data;

endmodule

// File: rtl/flash_slot_loader.sv
// Loads an image from a flash slot into a byte sink, then pads it.
// Optional: define LOADER_CRC_EN to add a CRC-16/CCITT output over the image bytes.
module flash_slot_loader
  import flash_pkg::*;
#(
  parameter int         ADDR_W     = 22,
  parameter int         IDX_W      = 4,
  parameter int         SLOT_SHIFT = 18,
  parameter logic [23:0] BASE_ADDR = 24'h400000,
  parameter int         PAD_BYTES  = 1024,
  parameter logic [7:0] PAD_VALUE  = 8'hFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reload,
  input  logic [IDX_W-1:0]  index,
  input  logic [ADDR_W:0]   length,
  output logic              flash_csn,
  output logic              flash_sck,
  output logic              flash_mosi,
  input  logic              flash_miso,
  output logic [ADDR_W-1:0] load_addr,
  output logic [7:0]        load_write_data,
  output logic              data_valid,
  input  logic              ready,
  output logic              busy,
  output logic              load_done
`ifdef LOADER_CRC_EN
  , output logic [15:0]     crc
`endif
);

  localparam int PAD_W = (PAD_BYTES > 1) ? $clog2(PAD_BYTES + 1) : 1;
  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PAD_BYTES - 1);

  load_state_t       r_state, w_next;
  logic [IDX_W-1:0]  r_index;
  logic [ADDR_W:0]   r_length;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_gap;
  logic [PAD_W-1:0]  r_pad_cnt;
  logic              r_busy;
  logic              r_load_done;

  logic              w_start, w_last_img, w_data_valid, w_xfer, w_wrap;
  logic [7:0]        w_data;
  logic [23:0]       w_cmd_addr;
  logic [ADDR_W:0]   w_len_m1;
  logic              w_streaming, w_byte_valid, w_ack;
  logic [7:0]        w_byte_data;

  assign w_cmd_addr = BASE_ADDR + (24'(r_index) << SLOT_SHIFT);
  assign w_len_m1   = r_length - {{ADDR_W{1'b0}}, 1'b1};
  assign w_ack      = (r_state == STREAM) && ready && !reload;

  spi_flash_stream u_spi (
    .clock        (clock),
    .reset        (reset),
    .i_start      (w_start),
    .i_stop       (reload || w_last_img),
    .i_ack        (w_ack),
    .i_addr       (w_cmd_addr),
    .i_miso       (flash_miso),
    .o_csn        (flash_csn),
    .o_sck        (flash_sck),
    .o_mosi       (flash_mosi),
    .o_streaming  (w_streaming),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_last_img   = 1'b0;
    w_data_valid = 1'b0;
    w_data       = 8'h00;
    case (r_state)
      STREAM: begin
        w_data_valid = w_byte_valid;
        w_data       = w_byte_data;
      end
      PAD: begin
        w_data_valid = 1'b1;
        w_data       = PAD_VALUE;
      end
      default: ;
    endcase
    w_xfer = w_data_valid && ready && !reload;
    w_wrap = &r_addr;
    case (r_state)
      // csn is held high for two cycles before the command starts
      CMD: begin
        w_start = (r_gap == 2'd1);
        if (r_gap == 2'd0 && w_streaming) w_next = STREAM;
      end
      STREAM: begin
        if (w_xfer && (w_wrap || ({1'b0, r_addr} == w_len_m1))) begin
          w_last_img = 1'b1;
          w_next     = (PAD_BYTES == 0 || w_wrap) ? DONE : PAD;
        end
      end
      PAD: begin
        if (w_xfer && (w_wrap || r_pad_cnt == PAD_LAST)) w_next = DONE;
      end
      default: ;
    endcase
    if (reload) begin
      w_start    = 1'b0;
      w_last_img = 1'b0;
      if (length == '0) w_next = (PAD_BYTES == 0) ? DONE : PAD;
      else              w_next = CMD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_index     <= '0;
      r_length    <= '0;
      r_addr      <= '0;
      r_gap       <= '0;
      r_pad_cnt   <= '0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
    end else if (reload) begin
      r_index     <= index;
      r_length    <= length;
      r_addr      <= '0;
      r_gap       <= 2'd2;
      r_pad_cnt   <= '0;
      r_busy      <= 1'b1;
      r_load_done <= 1'b0;
    end else begin
      if (r_gap != 2'd0) r_gap <= r_gap - 2'd1;
      // address saturates at the top so a full-size image never wraps
      if (w_xfer && !w_wrap) r_addr <= r_addr + ADDR_W'(1);
      if (w_xfer && r_state == PAD) r_pad_cnt <= r_pad_cnt + PAD_W'(1);
      if (r_state == DONE) begin
        r_busy      <= 1'b0;
        r_load_done <= 1'b1;
      end
    end
  end

`ifdef LOADER_CRC_EN
  logic [15:0] r_crc;

  always_ff @(posedge clock) begin
    if (reset || reload)                  r_crc <= 16'hFFFF;
    else if (w_xfer && r_state == STREAM) r_crc <= crc16_byte(r_crc, w_data);
  end

  assign crc = r_crc;
`endif

  assign load_addr       = r_addr;
  assign load_write_data = w_data;
  assign data_valid      = w_data_valid;
  assign busy            = r_busy;
  assign load_done       = r_load_done;

endmodule

// File: tb/tb_flash_slot_loader.sv
// Directed bench for flash_slot_loader with a behavioural SPI flash and byte sink.
module tb_flash_slot_loader;

  localparam int ADDR_W = 22;
  localparam int IDX_W  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              reload = 1'b0;
  logic              reload0 = 1'b0;
  logic              ready = 1'b1;
  logic [IDX_W-1:0]  index = '0;
  logic [ADDR_W:0]   length = '0;
  logic              flash_csn, flash_sck, flash_mosi;
  logic              flash_miso = 1'b0;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_write_data;
  logic              data_valid, busy, load_done;
  logic              csn0, sck0, mosi0, dv0, busy0, done0;
  logic [ADDR_W-1:0] addr0;
  logic [7:0]        data0;
`ifdef LOADER_CRC_EN
  logic [15:0]       crc, crc0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  flash_slot_loader dut (
    .clock(clock), .reset(reset), .reload(reload), .index(index), .length(length),
    .flash_csn(flash_csn), .flash_sck(flash_sck), .flash_mosi(flash_mosi), .flash_miso(flash_miso),
    .load_addr(load_addr), .load_write_data(load_write_data), .data_valid(data_valid),
    .ready(ready), .busy(busy), .load_done(load_done)
`ifdef LOADER_CRC_EN
    , .crc(crc)
`endif
  );

  flash_slot_loader #(.PAD_BYTES(0)) dut0 (
    .clock(clock), .reset(reset), .reload(reload0), .index(index), .length(length),
    .flash_csn(csn0), .flash_sck(sck0), .flash_mosi(mosi0), .flash_miso(1'b0),
    .load_addr(addr0), .load_write_data(data0), .data_valid(dv0),
    .ready(ready), .busy(busy0), .load_done(done0)
`ifdef LOADER_CRC_EN
    , .crc(crc0)
`endif
  );

  // flash contents
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h480000: return 8'h11;
      24'h480001: return 8'h22;
      24'h480002: return 8'h33;
      24'h480003: return 8'h44;
      default: begin
        if (a >= 24'h400000 && a < 24'h400009) return 8'h31 + a[7:0];
        return a[7:0] ^ 8'h5A;
      end
    endcase
  endfunction

  int          bitn = 0;
  int          n_cmds = 0;
  logic [31:0] cmd_sh = '0;
  logic [31:0] last_cmd = '0;
  logic        csn0_fell = 1'b0;

  always @(posedge flash_sck or posedge flash_csn) begin
    if (flash_csn) bitn = 0;
    else begin
      if (bitn < 32) cmd_sh = {cmd_sh[30:0], flash_mosi};
      if (bitn == 31) begin
        last_cmd = cmd_sh;
        n_cmds++;
      end
      bitn++;
    end
  end

  always @(negedge flash_sck) begin : mdl
    int j;
    logic [7:0] b;
    if (!flash_csn && bitn >= 32) begin
      j = bitn - 32;
      b = flash_byte(cmd_sh[23:0] + 24'(j / 8));
      flash_miso = b[7 - (j % 8)];
    end
  end

  always @(negedge csn0) csn0_fell = 1'b1;

  logic [ADDR_W-1:0] cap_addr[$];
  logic [7:0]        cap_data[$];

  always @(posedge clock) begin
    if (!reset && data_valid && ready && !reload) begin
      cap_addr.push_back(load_addr);
      cap_data.push_back(load_write_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reload(input logic [IDX_W-1:0] idx, input logic [ADDR_W:0] len);
    index  = idx;
    length = len;
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int i;
    i = 0;
    while (!load_done && i < max) begin
      tick();
      i++;
    end
    check_eq(tag, load_done, 1);
  endtask

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
  endtask

  initial begin
    int n0, bad, k, hi;
    logic [7:0] held;

    // reset values
    repeat (3) tick();
    check_eq("rst_csn", flash_csn, 1);
    check_eq("rst_sck", flash_sck, 0);
    check_eq("rst_mosi", flash_mosi, 0);
    check_eq("rst_addr", load_addr, 0);
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", load_done, 0);
    reset = 1'b0;
    repeat (5) tick();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_csn", flash_csn, 1);

    // basic load: slot 2, four bytes, then pad
    clear_cap();
    n0 = n_cmds;
    pulse_reload(4'd2, 23'd4);
    check_eq("ld_busy", busy, 1);
    check_eq("ld_done_clr", load_done, 0);
    wait_done("ld_done", 4000);
    check_eq("ld_cmd", last_cmd, 32'h03480000);
    check_eq("ld_ncmd", n_cmds - n0, 1);
    check_eq("ld_count", cap_data.size(), 1028);
    check_eq("ld_b0", cap_data[0], 8'h11);
    check_eq("ld_b1", cap_data[1], 8'h22);
    check_eq("ld_b2", cap_data[2], 8'h33);
    check_eq("ld_b3", cap_data[3], 8'h44);
    check_eq("ld_a3", cap_addr[3], 3);
    bad = 0;
    for (int i = 4; i < cap_data.size(); i++)
      if (cap_data[i] !== 8'hFF || cap_addr[i] !== ADDR_W'(i)) bad++;
    check_eq("ld_pad_bad", bad, 0);
    check_eq("ld_pad_last_addr", cap_addr[1027], 1027);
    check_eq("ld_end_addr", load_addr, 1028);
    check_eq("ld_end_busy", busy, 0);
    check_eq("ld_end_csn", flash_csn, 1);

    // sink stall on byte 1
    clear_cap();
    pulse_reload(4'd2, 23'd4);
    k = 0;
    while (!(data_valid && load_addr == 1) && k < 600) begin
      tick();
      k++;
    end
    check_eq("st_reach", k < 600, 1);
    ready = 1'b0;
    held = load_write_data;
    bad = 0;
    repeat (40) begin
      tick();
      if (flash_sck !== 1'b0 || load_write_data !== held || load_addr !== 1 || data_valid !== 1'b1) bad++;
    end
    check_eq("st_stable", bad, 0);
    check_eq("st_data", held, 8'h22);
    ready = 1'b1;
    wait_done("st_done", 4000);
    check_eq("st_count", cap_data.size(), 1028);
    check_eq("st_b0", cap_data[0], 8'h11);
    check_eq("st_b1", cap_data[1], 8'h22);
    check_eq("st_b2", cap_data[2], 8'h33);
    check_eq("st_b3", cap_data[3], 8'h44);

    // abort mid-stream with a new slot
    pulse_reload(4'd2, 23'd4);
    k = 0;
    while (load_addr != 2 && k < 600) begin
      tick();
      k++;
    end
    check_eq("ab_reach", k < 600, 1);
    clear_cap();
    n0 = n_cmds;
    index = 4'd5;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check_eq("ab_csn_hi", flash_csn, 1);
    check_eq("ab_addr0", load_addr, 0);
    hi = 1;
    while (flash_csn && hi < 40) begin
      tick();
      if (flash_csn) hi++;
    end
    check_eq("ab_gap", (hi >= 2 && hi < 40), 1);
    wait_done("ab_done", 4000);
    check_eq("ab_cmd", last_cmd, 32'h03540000);
    check_eq("ab_ncmd", n_cmds - n0, 1);
    check_eq("ab_count", cap_data.size(), 1028);
    check_eq("ab_a0", cap_addr[0], 0);
    check_eq("ab_b0", cap_data[0], 8'h5A);
    check_eq("ab_b3", cap_data[3], 8'h59);

    // zero length: pad-only on the main instance, immediate done without pad
    clear_cap();
    n0 = n_cmds;
    index = 4'd0;
    length = '0;
    reload = 1'b1;
    reload0 = 1'b1;
    tick();
    reload = 1'b0;
    reload0 = 1'b0;
    check_eq("z0_done_1", done0, 0);
    check_eq("z0_busy_1", busy0, 1);
    tick();
    check_eq("z0_done_2", done0, 1);
    check_eq("z0_busy_2", busy0, 0);
    wait_done("z_done", 4000);
    check_eq("z_count", cap_data.size(), 1024);
    check_eq("z_last_addr", cap_addr[1023], 1023);
    check_eq("z_ncmd", n_cmds - n0, 0);
    check_eq("z0_csn_fell", csn0_fell, 0);

    // reset during CMD, with a simultaneous reload
    pulse_reload(4'd2, 23'd4);
    repeat (10) tick();
    check_eq("rc_csn_low", flash_csn, 0);
    reset = 1'b1;
    reload = 1'b1;
    tick();
    reset = 1'b0;
    reload = 1'b0;
    check_eq("rc_csn", flash_csn, 1);
    check_eq("rc_sck", flash_sck, 0);
    check_eq("rc_mosi", flash_mosi, 0);
    check_eq("rc_addr", load_addr, 0);
    check_eq("rc_valid", data_valid, 0);
    check_eq("rc_busy", busy, 0);
    check_eq("rc_done", load_done, 0);
    repeat (3) tick();
    check_eq("rc_idle_busy", busy, 0);
    check_eq("rc_idle_csn", flash_csn, 1);

`ifdef LOADER_CRC_EN
    // CRC over "123456789" stored in slot 0
    clear_cap();
    pulse_reload(4'd0, 23'd9);
    wait_done("crc_done", 4000);
    check_eq("crc_b8", cap_data[8], 8'h39);
    check_eq("crc_val", crc, 16'h29B1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flash_slot_loader.md
FLASH_SLOT_LOADER -- requirements
Module: flash_slot_loader

Interface
REQ-001 Parameter ADDR_W, default 22, sets the width of load_addr and the maximum image size of 2^ADDR_W bytes.
REQ-002 Parameter IDX_W, default 4, sets the width of the slot index.
REQ-003 Parameter SLOT_SHIFT, default 18, is log2 of the slot stride in flash.
REQ-004 Parameter BASE_ADDR, default 24'h400000, is the flash byte address of slot 0.
REQ-005 Parameter PAD_BYTES, default 1024, is the count of pad bytes emitted after the image; 0 disables the pad phase.
REQ-006 Parameter PAD_VALUE, default 8'hFF, is the pad byte value.
REQ-007 Port clock, input, 1 bit: clock.
REQ-008 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-009 Port reload, input, 1 bit: single-cycle pulse that starts or restarts a load.
REQ-010 Port index, input, IDX_W bits: slot number, sampled on reload.
REQ-011 Port length, input, ADDR_W+1 bits: image byte count, sampled on reload.
REQ-012 Ports flash_csn (out, 1), flash_sck (out, 1), flash_mosi (out, 1), flash_miso (in, 1): SPI mode 0 flash interface.
REQ-013 Port load_addr, output, ADDR_W bits: destination address of the current byte.
REQ-014 Port load_write_data, output, 8 bits: current byte.
REQ-015 Port data_valid, output, 1 bit: byte offered to the sink.
REQ-016 Port ready, input, 1 bit: sink accepts the byte; a transfer occurs when data_valid and ready are both high.
REQ-017 Ports busy and load_done, output, 1 bit each: load in progress, and load complete (held high until the next reload).

Function
REQ-018 The FSM states SHALL be IDLE, CMD, STREAM, PAD, DONE.
REQ-019 On reload the block SHALL latch index and length, clear load_addr and load_done, raise busy, and enter CMD on the next cycle.
REQ-020 CMD SHALL drive csn low and shift out 0x03 followed by a 24-bit address, MSB first, with sck = clock/2 (64 clock cycles); the address is (BASE_ADDR + (index << SLOT_SHIFT)) mod 2^24.
REQ-021 STREAM SHALL read bytes continuously on a single csn-low burst, one byte per 16 clocks, without reissuing the command.
REQ-022 While data_valid is high and ready is low, the block SHALL hold sck low, with data and address stable.
REQ-023 Each transfer SHALL increment load_addr by 1.
REQ-024 After the transfer of byte length-1, the block SHALL raise csn and enter PAD, or DONE if PAD_BYTES is 0.
REQ-025 If length is 0, the block SHALL skip CMD and STREAM, and csn SHALL stay high.
REQ-026 PAD SHALL offer PAD_VALUE at consecutive addresses, one byte per cycle subject to ready, for PAD_BYTES transfers.
REQ-027 DONE SHALL set load_done=1 and busy=0 one cycle after the final transfer; load_addr then holds.
REQ-028 A reload in any state SHALL abort the current load: csn goes high the next cycle and stays high for at least 2 cycles before the new CMD; any same-cycle transfer is discarded.
REQ-029 A load that reaches the address wrap (length = 2^ADDR_W) SHALL end exactly at address 2^ADDR_W - 1 with no wrap.
REQ-030 After reset, with no reload, the block SHALL stay in IDLE.

Reset
REQ-031 Reset SHALL force state IDLE, csn=1, sck=0, mosi=0, load_addr=0, data_valid=0, busy=0, load_done=0, and clear latched index and length.
REQ-032 Reset during CMD or STREAM SHALL deassert csn in the same clock edge; reset SHALL take priority over reload.

Configuration
REQ-033 With LOADER_CRC_EN defined, the block SHALL add output crc[15:0], a CRC-16/CCITT (polynomial 0x1021, init 0xFFFF) over the image bytes only, excluding pad; crc SHALL be cleared on reload and valid while load_done=1.
REQ-034 Without LOADER_CRC_EN, the crc port and its logic SHALL be absent.

Structure
REQ-035 The SPI opcode 0x03, the FSM state enum and the CRC polynomial SHALL live in the shared package flash_pkg.
REQ-036 The SPI shifting (command, address, byte receive, sck stall) SHALL be the sub-module spi_flash_stream; the top level holds the FSM, counters, pad and CRC.

Verification
REQ-037 Scenario: index=2, length=4, flash model data 11 22 33 44 at 0x480000 -> MOSI carries 03 48 00 00; bytes 11..44 at addr 0..3; then 1024 bytes of FF at addr 4..1027; load_done=1.
REQ-038 Scenario: ready held low for 40 cycles on byte 1 -> sck is frozen, data and address are stable, no byte is lost or duplicated.
REQ-039 Scenario: reload with index=5 issued mid-STREAM -> csn is high for at least 2 cycles, the new command address is 0x540000, and load_addr restarts at 0.
REQ-040 Scenario: length=0, PAD_BYTES=0 -> csn never falls, and load_done=1 two cycles after reload.
REQ-041 Scenario: reset asserted during CMD -> csn=1 and all outputs are at reset values after that edge.
REQ-042 Scenario: LOADER_CRC_EN defined, image "123456789" -> crc=16'h29B1 at load_done.
